rr_req_gnt_arbiter: RTL and testbench

- Round-robin arbiter sharing one resource among NUM_REQ level-sensitive requesters.
- Issues a registered one-hot grant, holds it for at most HOLD_MAX cycles per tenure, and rotates priority after every tenure.
- Per-requester wait counters raise a sticky starvation flag when a request waits MAX_WAIT cycles; the REQ/GNT bounded-latency property in the bench checks against this flag.
- Sits between requester agents and the shared resource's GNT input.

---
 rtl/rr_req_gnt_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_req_gnt_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin request/grant arbiter with bounded tenure and per-requester starvation flags.
// Optional `RR_ARB_LOCK_EN adds a lock input that extends the current owner's tenure past HOLD_MAX.
module rr_req_gnt_arbiter #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned HOLD_MAX = 4,
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
`ifdef RR_ARB_LOCK_EN
   input  logic                       lock,
`endif
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       gnt_valid,
   output logic [$clog2(NUM_REQ)-1:0] gnt_id,
   output logic [NUM_REQ-1:0]         starve
);

   localparam int unsigned IDW = $clog2(NUM_REQ);
   localparam int unsigned HCW = $clog2(HOLD_MAX + 1);
   localparam int unsigned WCW = $clog2(MAX_WAIT + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [IDW-1:0]     id_q, id_d;
   logic [HCW-1:0]     hold_q, hold_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] starve_q, starve_d;
   logic [WCW-1:0]     wait_q [NUM_REQ];
   logic [WCW-1:0]     wait_d [NUM_REQ];

   logic [IDW-1:0]     ptr_after;
   logic [IDW:0]       pick;
   logic               rel;
   logic               hold_full;
   logic               lock_hold;

   // Descending scan so the last hit written is the first set bit at or above start.
   function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IDW-1:0]     start);
      logic [IDW:0] res;
      int unsigned  idx;
      res = '0;
      for (int unsigned k = NUM_REQ; k > 0; k--) begin
         idx = ({{(32-IDW){1'b0}}, start} + k - 1) % NUM_REQ;
         if (r[IDW'(idx)]) res = {1'b1, IDW'(idx)};
      end
      return res;
   endfunction

`ifdef RR_ARB_LOCK_EN
   assign lock_hold = lock;
`else
   assign lock_hold = 1'b0;
`endif

   assign hold_full = (hold_q == HCW'(HOLD_MAX));
   assign ptr_after = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
   assign rel       = !req[id_q] || (hold_full && !lock_hold);
   assign pick      = rr_pick(req, (state_q == IDLE) ? ptr_q : ptr_after);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      case (state_q)
         IDLE: begin
            if (pick[IDW]) begin
               state_d            = BUSY;
               id_d               = pick[IDW-1:0];
               hold_d             = HCW'(1);
               gnt_d              = '0;
               gnt_d[pick[IDW-1:0]] = 1'b1;
            end
         end
         BUSY: begin
            if (rel) begin
               ptr_d = ptr_after;
               gnt_d = '0;
               if (pick[IDW]) begin
                  id_d                 = pick[IDW-1:0];
                  hold_d               = HCW'(1);
                  gnt_d[pick[IDW-1:0]] = 1'b1;
               end else begin
                  state_d = IDLE;
                  id_d    = '0;
                  hold_d  = '0;
               end
            end else if (!hold_full) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      starve_d = starve_q;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         wait_d[i] = '0;
         if (req[i] && !gnt_q[i])
            wait_d[i] = (wait_q[i] == WCW'(MAX_WAIT)) ? wait_q[i] : wait_q[i] + 1'b1;
         if (wait_d[i] == WCW'(MAX_WAIT)) starve_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         id_q     <= '0;
         hold_q   <= '0;
         gnt_q    <= '0;
         starve_q <= '0;
         for (int unsigned i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         hold_q   <= hold_d;
         gnt_q    <= gnt_d;
         starve_q <= starve_d;
         for (int unsigned i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = |gnt_q;
   assign gnt_id    = id_q;
   assign starve    = starve_q;

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Scoreboard bench for rr_req_gnt_arbiter: default instance plus a MAX_WAIT=3 instance for starvation.
module tb_rr_req_gnt_arbiter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] req_a, req_b;
   logic [3:0] gnt_a, gnt_b, st_a, st_b;
   logic       gv_a, gv_b;
   logic [1:0] id_a, id_b;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit         dsel;
      logic [3:0] gnt;
      logic [3:0] starve;
      string      name;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   rr_req_gnt_arbiter dut_a (
      .clk(clk), .reset_n(reset_n),
`ifdef RR_ARB_LOCK_EN
      .lock(1'b0),
`endif
      .req(req_a), .gnt(gnt_a), .gnt_valid(gv_a), .gnt_id(id_a), .starve(st_a)
   );

   rr_req_gnt_arbiter #(.MAX_WAIT(3)) dut_b (
      .clk(clk), .reset_n(reset_n),
`ifdef RR_ARB_LOCK_EN
      .lock(1'b0),
`endif
      .req(req_b), .gnt(gnt_b), .gnt_valid(gv_b), .gnt_id(id_b), .starve(st_b)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compares every queued expectation against the selected instance.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t e;
         logic [1:0] eid;
         e   = sb.pop_front();
         eid = '0;
         for (int i = 0; i < 4; i++) if (e.gnt[i]) eid = 2'(i);
         if (!e.dsel) begin
            check({e.name, ".gnt"},       32'(gnt_a), 32'(e.gnt));
            check({e.name, ".gnt_valid"}, 32'(gv_a),  32'(|e.gnt));
            check({e.name, ".gnt_id"},    32'(id_a),  32'(eid));
            check({e.name, ".starve"},    32'(st_a),  32'(e.starve));
         end else begin
            check({e.name, ".gnt"},       32'(gnt_b), 32'(e.gnt));
            check({e.name, ".gnt_valid"}, 32'(gv_b),  32'(|e.gnt));
            check({e.name, ".gnt_id"},    32'(id_b),  32'(eid));
            check({e.name, ".starve"},    32'(st_b),  32'(e.starve));
         end
      end
   end

   // Drive inputs, take one edge, then post the expected post-edge outputs.
   task automatic cyc(input logic [3:0] ra, input logic [3:0] rb, input logic rn,
                      input bit dsel, input logic [3:0] eg, input logic [3:0] es,
                      input string nm);
      exp_t e;
      req_a   = ra;
      req_b   = rb;
      reset_n = rn;
      @(posedge clk);
      #1;
      e.dsel = dsel; e.gnt = eg; e.starve = es; e.name = nm;
      sb.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      req_a = '0; req_b = '0; reset_n = 1'b0;

      // Reset then idle
      cyc(4'b0000, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, "reset");
      cyc(4'b0000, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, "reset");
      for (int i = 0; i < 10; i++) cyc(4'b0000, 4'b0000, 1'b1, 0, 4'b0000, 4'b0000, "idle");

      // Sole requester: re-granted across tenures without a gap
      for (int i = 0; i < 10; i++) cyc(4'b0100, 4'b0000, 1'b1, 0, 4'b0100, 4'b0000, "single");
      cyc(4'b0000, 4'b0000, 1'b1, 0, 4'b0000, 4'b0000, "single_drop");

      // Rotation from ptr=0, four cycles per tenure
      cyc(4'b0000, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, "rst_rot");
      for (int i = 0; i < 20; i++) begin
         logic [3:0] oh;
         oh = 4'b0001 << ((i / 4) % 4);
         cyc(4'b1111, 4'b0000, 1'b1, 0, oh, 4'b0000, "rotate");
      end
      cyc(4'b0000, 4'b0000, 1'b1, 0, 4'b0000, 4'b0000, "rotate_drop");

      // Early release after two grant cycles
      cyc(4'b0000, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, "rst_early");
      cyc(4'b0011, 4'b0000, 1'b1, 0, 4'b0001, 4'b0000, "early");
      cyc(4'b0011, 4'b0000, 1'b1, 0, 4'b0001, 4'b0000, "early");
      cyc(4'b0010, 4'b0000, 1'b1, 0, 4'b0010, 4'b0000, "early_move");
      cyc(4'b0010, 4'b0000, 1'b1, 0, 4'b0010, 4'b0000, "early");
      cyc(4'b0000, 4'b0000, 1'b1, 0, 4'b0000, 4'b0000, "early_idle");

      // Reset mid-tenure: ptr must return to 0 (ptr is 2 going in)
      cyc(4'b1000, 4'b0000, 1'b1, 0, 4'b1000, 4'b0000, "midrst");
      cyc(4'b1000, 4'b0000, 1'b1, 0, 4'b1000, 4'b0000, "midrst");
      cyc(4'b1001, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, "midrst_drop");
      cyc(4'b1001, 4'b0000, 1'b1, 0, 4'b0001, 4'b0000, "midrst_ptr0");
      cyc(4'b1001, 4'b0000, 1'b1, 0, 4'b0001, 4'b0000, "midrst_hold");
      cyc(4'b0000, 4'b0000, 1'b1, 0, 4'b0000, 4'b0000, "midrst_idle");

      // Starvation on the MAX_WAIT=3 instance
      cyc(4'b0000, 4'b0011, 1'b1, 1, 4'b0001, 4'b0000, "starve_w1");
      cyc(4'b0000, 4'b0011, 1'b1, 1, 4'b0001, 4'b0000, "starve_w2");
      cyc(4'b0000, 4'b0011, 1'b1, 1, 4'b0001, 4'b0010, "starve_set");
      cyc(4'b0000, 4'b0011, 1'b1, 1, 4'b0001, 4'b0010, "starve_hold");
      cyc(4'b0000, 4'b0011, 1'b1, 1, 4'b0010, 4'b0010, "starve_rot");
      cyc(4'b0000, 4'b0000, 1'b1, 1, 4'b0000, 4'b0010, "starve_sticky");
      cyc(4'b0000, 4'b0000, 1'b1, 1, 4'b0000, 4'b0010, "starve_sticky");
      cyc(4'b0000, 4'b0000, 1'b0, 1, 4'b0000, 4'b0000, "starve_clear");
      cyc(4'b0000, 4'b0000, 1'b1, 1, 4'b0000, 4'b0000, "starve_after");

      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
